// File: rtl/alu_pipe_if.sv
// Handshake and operand/result bundle for alu_pipe.
// master = producer/consumer side, slave = the ALU pipeline.
interface alu_pipe_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       OPCODE;
    logic [WIDTH-1:0] OP1;
    logic [WIDTH-1:0] OP2;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] RESULT;
    logic [3:0]       FLAGS;

    modport master (
        output in_valid, OPCODE, OP1, OP2, out_ready,
        input  in_ready, out_valid, RESULT, FLAGS
    );

    modport slave (
        input  in_valid, OPCODE, OP1, OP2, out_ready,
        output in_ready, out_valid, RESULT, FLAGS
    );
endinterface

// File: rtl/alu_pipe.sv
// Two-stage valid/ready ALU with running accumulator; FLAGS = {N, V, C, Z}.
// Define ALU_PIPE_SAT_EN to make ADD/SUB saturate on signed overflow.
module alu_pipe #(
    parameter int WIDTH = 8,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic       clk,
    input  logic       rst,
    alu_pipe_if.slave  bus
);

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100,
        OP_SHL = 3'b101,
        OP_SHR = 3'b110,
        OP_ACC = 3'b111
    } op_e;

    logic             vld_p1_q, vld_p1_d;
    op_e              op_p1_q, op_p1_d;
    logic [WIDTH-1:0] a_p1_q, a_p1_d;
    logic [WIDTH-1:0] b_p1_q, b_p1_d;

    logic             vld_p2_q, vld_p2_d;
    logic [WIDTH-1:0] res_p2_q, res_p2_d;
    logic [3:0]       flg_p2_q, flg_p2_d;
    logic [WIDTH-1:0] acc_q, acc_d;

    logic                    s1_adv, s2_adv;
    logic signed [WIDTH:0]   add_s, sub_s, acc_s;
    logic [WIDTH:0]          add_x, acc_x;
    logic [WIDTH-1:0]        alu_res;
    logic                    alu_c, alu_v;

`ifdef ALU_PIPE_SAT_EN
    // Sign-extended sum: the top bit is the true sign, so on overflow it picks the rail.
    function automatic logic [WIDTH-1:0] sat_fn(input logic signed [WIDTH:0] s);
        if (s[WIDTH] != s[WIDTH-1])
            return s[WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        return s[WIDTH-1:0];
    endfunction
`endif

    assign s2_adv       = !vld_p2_q || bus.out_ready;
    assign s1_adv       = !vld_p1_q || s2_adv;
    assign bus.in_ready = s1_adv && !rst;

    assign bus.out_valid = vld_p2_q;
    assign bus.RESULT    = res_p2_q;
    assign bus.FLAGS     = flg_p2_q;

    // ---- S1 -> S2 combinational execute ----
    always_comb begin
        add_x = {1'b0, a_p1_q} + {1'b0, b_p1_q};
        acc_x = {1'b0, acc_q} + {1'b0, a_p1_q};
        add_s = $signed({a_p1_q[WIDTH-1], a_p1_q}) + $signed({b_p1_q[WIDTH-1], b_p1_q});
        sub_s = $signed({a_p1_q[WIDTH-1], a_p1_q}) - $signed({b_p1_q[WIDTH-1], b_p1_q});
        acc_s = $signed({acc_q[WIDTH-1], acc_q}) + $signed({a_p1_q[WIDTH-1], a_p1_q});
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        case (op_p1_q)
            OP_ADD: begin
                alu_c = add_x[WIDTH];
                alu_v = add_s[WIDTH] ^ add_s[WIDTH-1];
`ifdef ALU_PIPE_SAT_EN
                alu_res = sat_fn(add_s);
`else
                alu_res = add_s[WIDTH-1:0];
`endif
            end
            OP_SUB: begin
                alu_c = a_p1_q < b_p1_q;
                alu_v = sub_s[WIDTH] ^ sub_s[WIDTH-1];
`ifdef ALU_PIPE_SAT_EN
                alu_res = sat_fn(sub_s);
`else
                alu_res = sub_s[WIDTH-1:0];
`endif
            end
            OP_AND: alu_res = a_p1_q & b_p1_q;
            OP_OR:  alu_res = a_p1_q | b_p1_q;
            OP_XOR: alu_res = a_p1_q ^ b_p1_q;
            OP_SHL: alu_res = a_p1_q << b_p1_q[SHW-1:0];
            OP_SHR: alu_res = a_p1_q >> b_p1_q[SHW-1:0];
            OP_ACC: begin
                alu_res = acc_x[WIDTH-1:0];
                alu_c   = acc_x[WIDTH];
                alu_v   = acc_s[WIDTH] ^ acc_s[WIDTH-1];
            end
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        vld_p1_d = vld_p1_q;
        op_p1_d  = op_p1_q;
        a_p1_d   = a_p1_q;
        b_p1_d   = b_p1_q;
        if (s1_adv) begin
            vld_p1_d = bus.in_valid;
            if (bus.in_valid) begin
                op_p1_d = op_e'(bus.OPCODE);
                a_p1_d  = bus.OP1;
                b_p1_d  = bus.OP2;
            end
        end

        vld_p2_d = vld_p2_q;
        res_p2_d = res_p2_q;
        flg_p2_d = flg_p2_q;
        acc_d    = acc_q;
        // The accumulator commits together with S2 so the next ACC in S1 sees it.
        if (s2_adv) begin
            vld_p2_d = vld_p1_q;
            if (vld_p1_q) begin
                res_p2_d = alu_res;
                flg_p2_d = {alu_res[WIDTH-1], alu_v, alu_c, (alu_res == '0)};
                if (op_p1_q == OP_ACC)
                    acc_d = alu_res;
            end
        end
    end

    // ---- S1 operand register (data only) ----
    always_ff @(posedge clk) begin
        op_p1_q <= op_p1_d;
        a_p1_q  <= a_p1_d;
        b_p1_q  <= b_p1_d;
    end

    // ---- control, S2 result and accumulator ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p1_q <= 1'b0;
            vld_p2_q <= 1'b0;
            res_p2_q <= '0;
            flg_p2_q <= 4'b0000;
            acc_q    <= '0;
        end else begin
            vld_p1_q <= vld_p1_d;
            vld_p2_q <= vld_p2_d;
            res_p2_q <= res_p2_d;
            flg_p2_q <= flg_p2_d;
            acc_q    <= acc_d;
        end
    end

endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe: directed cases plus randomized traffic
// scored against an arithmetic reference model and an in-order queue.
module tb_alu_pipe;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    alu_pipe_if #(.WIDTH(W)) bus();
    alu_pipe #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

    int total = 0;
    int bad   = 0;
    longint m_acc = 0;
    logic [W+3:0] expq[$];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        bus.in_valid = v;
        bus.OPCODE   = op;
        bus.OP1      = a;
        bus.OP2      = b;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        m_acc = 0;
    endtask

    // Reference: plain integer arithmetic on unsigned/signed interpretations.
    function automatic logic [W+3:0] model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        longint m, h, ua, ub, sa, sb, sacc, r, sr, sh;
        logic c, v;
        logic [W-1:0] res;
        m  = longint'(1) << W;
        h  = m / 2;
        ua = longint'(a);
        ub = longint'(b);
        sa = (ua >= h) ? ua - m : ua;
        sb = (ub >= h) ? ub - m : ub;
        sacc = (m_acc >= h) ? m_acc - m : m_acc;
        sh = ub % (longint'(1) << $clog2(W));
        r = 0; sr = 0; c = 1'b0;
        case (op)
            3'd0: begin r = ua + ub; c = (r >= m); sr = sa + sb; end
            3'd1: begin r = ua - ub + m; c = (ua < ub); sr = sa - sb; end
            3'd2: r = ua & ub;
            3'd3: r = ua | ub;
            3'd4: r = ua ^ ub;
            3'd5: r = ua << sh;
            3'd6: r = ua >> sh;
            default: begin r = m_acc + ua; c = (r >= m); sr = sacc + sa; end
        endcase
        v = (sr > h - 1) || (sr < -h);
        r = r % m;
`ifdef ALU_PIPE_SAT_EN
        if ((op == 3'd0 || op == 3'd1) && v)
            r = (sr > 0) ? h - 1 : h;
`endif
        if (op == 3'd7)
            m_acc = r;
        res = r[W-1:0];
        return {res, res[W-1], v, c, (res == '0)};
    endfunction

    function automatic logic [W-1:0] pick();
        logic [31:0] t;
        t = $urandom;
        case ($urandom_range(0, 5))
            0: return 8'h00;
            1: return 8'hFF;
            2: return 8'h80;
            3: return 8'h7F;
            default: return t[W-1:0];
        endcase
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        bus.out_ready = 1'b0;
        drive(1'b0, 3'd0, '0, '0);
        #2;
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", bus.out_valid); end
        total++; if (bus.RESULT !== 8'h00) begin bad++; $display("FAIL reset_result got=%h want=00", bus.RESULT); end
        total++; if (bus.FLAGS !== 4'b0000) begin bad++; $display("FAIL reset_flags got=%b want=0000", bus.FLAGS); end
        total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready got=%b want=0", bus.in_ready); end
        step();
        rst = 1'b0;
        #1;
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL release_in_ready got=%b want=1", bus.in_ready); end
    endtask

    task automatic test_add_wrap();
        step();
        bus.out_ready = 1'b1;
        drive(1'b1, 3'd0, 8'hFF, 8'h01);
        #1;
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL add_accept got=%b want=1", bus.in_ready); end
        step();
        drive(1'b0, 3'd0, '0, '0);
        #1;
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL add_lat1 out_valid got=%b want=0", bus.out_valid); end
        step();
        #1;
        total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL add_lat2 out_valid got=%b want=1", bus.out_valid); end
        total++; if ({bus.RESULT, bus.FLAGS} !== {8'h00, 4'b0011}) begin bad++; $display("FAIL add_wrap got=%h/%b want=00/0011", bus.RESULT, bus.FLAGS); end
        step();
        #1;
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL add_single got=%b want=0", bus.out_valid); end
    endtask

    task automatic test_sub_overflow();
        logic [2:0]   ops[2] = '{3'd1, 3'd0};
        logic [W-1:0] as[2]  = '{8'h05, 8'h70};
        logic [W-1:0] bs[2]  = '{8'h07, 8'h20};
        logic [W+3:0] ex[2];
        ex[0] = {8'hFE, 4'b1010};
`ifdef ALU_PIPE_SAT_EN
        ex[1] = {8'h7F, 4'b0100};
`else
        ex[1] = {8'h90, 4'b1100};
`endif
        for (int k = 0; k < 2; k++) begin
            step();
            bus.out_ready = 1'b1;
            drive(1'b1, ops[k], as[k], bs[k]);
            step();
            drive(1'b0, 3'd0, '0, '0);
            step();
            #1;
            total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL dir%0d_valid got=%b want=1", k, bus.out_valid); end
            total++; if ({bus.RESULT, bus.FLAGS} !== ex[k]) begin bad++; $display("FAIL dir%0d got=%h/%b want=%h/%b", k, bus.RESULT, bus.FLAGS, ex[k][W+3:4], ex[k][3:0]); end
            step();
        end
    endtask

    task automatic test_backpressure();
        logic [2:0]   ops[3] = '{3'd0, 3'd4, 3'd2};
        logic [W-1:0] as[3]  = '{8'h01, 8'h0F, 8'hF0};
        logic [W-1:0] bs[3]  = '{8'h02, 8'hF0, 8'h3C};
        logic [W+3:0] ex[3]  = '{{8'h03, 4'b0000}, {8'hFF, 4'b1000}, {8'h30, 4'b0000}};
        int acc_n = 0;
        int pop_n = 0;
        logic acc_now, pop_now;
        step();
        for (int i = 0; i < 20; i++) begin
            bus.out_ready = (i >= 5);
            if (acc_n < 3) drive(1'b1, ops[acc_n], as[acc_n], bs[acc_n]);
            else           drive(1'b0, 3'd0, '0, '0);
            #1;
            acc_now = bus.in_valid && bus.in_ready;
            pop_now = bus.out_valid && bus.out_ready;
            if (i == 4) begin
                total++; if (acc_n !== 2) begin bad++; $display("FAIL bp_accepted got=%0d want=2", acc_n); end
                total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready got=%b want=0", bus.in_ready); end
                total++; if ({bus.RESULT, bus.FLAGS} !== ex[0]) begin bad++; $display("FAIL bp_hold got=%h/%b want=03/0000", bus.RESULT, bus.FLAGS); end
            end
            if (pop_now) begin
                if (pop_n < 3) begin
                    total++; if ({bus.RESULT, bus.FLAGS} !== ex[pop_n]) begin bad++; $display("FAIL bp_order%0d got=%h/%b want=%h/%b", pop_n, bus.RESULT, bus.FLAGS, ex[pop_n][W+3:4], ex[pop_n][3:0]); end
                end
                pop_n++;
            end
            if (acc_now) acc_n++;
            step();
        end
        total++; if (pop_n !== 3) begin bad++; $display("FAIL bp_count got=%0d want=3", pop_n); end
    endtask

    task automatic test_acc();
        logic [W-1:0] ex[3] = '{8'h05, 8'h0A, 8'h0F};
        int n = 0;
        do_reset();
        bus.out_ready = 1'b1;
        drive(1'b1, 3'd7, 8'h05, 8'hAA);
        for (int i = 0; i < 10; i++) begin
            step();
            if (i == 2) drive(1'b0, 3'd0, '0, '0);
            #1;
            if (bus.out_valid && bus.out_ready) begin
                if (n < 3) begin
                    total++; if ({bus.RESULT, bus.FLAGS} !== {ex[n], 4'b0000}) begin bad++; $display("FAIL acc%0d got=%h/%b want=%h/0000", n, bus.RESULT, bus.FLAGS, ex[n]); end
                end
                n++;
            end
        end
        total++; if (n !== 3) begin bad++; $display("FAIL acc_count got=%0d want=3", n); end
    endtask

    task automatic test_reset_midflight();
        int seen = 0;
        step();
        bus.out_ready = 1'b0;
        drive(1'b1, 3'd7, 8'h11, 8'h00);
        step();
        step();
        drive(1'b0, 3'd0, '0, '0);
        #1;
        total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL mid_full got=%b want=1", bus.out_valid); end
        rst = 1'b1;
        #1;
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL mid_async got=%b want=0", bus.out_valid); end
        total++; if ({bus.RESULT, bus.FLAGS} !== 12'h000) begin bad++; $display("FAIL mid_clear got=%h/%b want=00/0000", bus.RESULT, bus.FLAGS); end
        step();
        step();
        rst = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            if (bus.out_valid) seen++;
        end
        total++; if (seen !== 0) begin bad++; $display("FAIL mid_stale got=%0d want=0", seen); end
        drive(1'b1, 3'd7, 8'h03, 8'h55);
        step();
        drive(1'b0, 3'd0, '0, '0);
        step();
        #1;
        total++; if ({bus.out_valid, bus.RESULT} !== {1'b1, 8'h03}) begin bad++; $display("FAIL mid_acc got=%b/%h want=1/03", bus.out_valid, bus.RESULT); end
    endtask

    task automatic test_random();
        logic         stall_prev = 1'b0;
        logic [W+3:0] held = '0;
        logic [W+3:0] e;
        logic [2:0]   op;
        logic [W-1:0] a, b;
        do_reset();
        expq.delete();
        for (int i = 0; i < 600; i++) begin
            op = 3'($urandom_range(0, 7));
            a  = pick();
            b  = pick();
            drive(($urandom_range(0, 9) < 7), op, a, b);
            bus.out_ready = (i >= 560) || ($urandom_range(0, 9) < 6);
            if (i >= 560) bus.in_valid = 1'b0;
            #1;
            if (stall_prev) begin
                total++; if ({bus.out_valid, bus.RESULT, bus.FLAGS} !== {1'b1, held}) begin bad++; $display("FAIL rnd_stable cyc=%0d got=%b/%h want=1/%h", i, bus.out_valid, {bus.RESULT, bus.FLAGS}, held); end
            end
            if (bus.out_valid && bus.out_ready) begin
                if (expq.size() == 0) begin
                    total++; bad++; $display("FAIL rnd_extra cyc=%0d got=%h want=none", i, {bus.RESULT, bus.FLAGS});
                end else begin
                    e = expq.pop_front();
                    total++; if ({bus.RESULT, bus.FLAGS} !== e) begin bad++; $display("FAIL rnd_data cyc=%0d got=%h/%b want=%h/%b", i, bus.RESULT, bus.FLAGS, e[W+3:4], e[3:0]); end
                end
            end
            stall_prev = bus.out_valid && !bus.out_ready;
            held = {bus.RESULT, bus.FLAGS};
            if (bus.in_valid && bus.in_ready) expq.push_back(model(op, a, b));
            step();
        end
        total++; if (expq.size() !== 0) begin bad++; $display("FAIL rnd_lost got=%0d want=0", expq.size()); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_add_wrap();
        test_sub_overflow();
        test_backpressure();
        test_acc();
        test_reset_midflight();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
